// File: rtl/eda_pkg.sv
// Shared types and constants for the regional-max scan controller.
// State encoding and neighbour bit positions live here so that every block agrees on them.
package eda_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Neighbour bit positions within the 8-bit validity mask.
  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_W  = 3;
  localparam int NB_E  = 4;
  localparam int NB_SW = 5;
  localparam int NB_S  = 6;
  localparam int NB_SE = 7;

endpackage

// File: rtl/eda_nbr_mask.sv
// Combinational boundary mask: marks which of the 8 neighbours of (row, col) lie inside the image.
module eda_nbr_mask
  import eda_pkg::*;
#(
  parameter int M  = 16,
  parameter int N  = 16,
  parameter int RW = (M > 1) ? $clog2(M) : 1,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output logic [7:0]    mask
);

  logic edge_top;
  logic edge_bot;
  logic edge_lft;
  logic edge_rgt;

  assign edge_top = (row == '0);
  assign edge_bot = (row == RW'(M - 1));
  assign edge_lft = (col == '0);
  assign edge_rgt = (col == CW'(N - 1));

  // Clears combine, so corners lose five neighbours and a 1-wide image loses more.
  always_comb begin
    mask = 8'hFF;
    if (edge_top) begin
      mask[NB_NW] = 1'b0;
      mask[NB_N]  = 1'b0;
      mask[NB_NE] = 1'b0;
    end
    if (edge_bot) begin
      mask[NB_SW] = 1'b0;
      mask[NB_S]  = 1'b0;
      mask[NB_SE] = 1'b0;
    end
    if (edge_lft) begin
      mask[NB_NW] = 1'b0;
      mask[NB_W]  = 1'b0;
      mask[NB_SW] = 1'b0;
    end
    if (edge_rgt) begin
      mask[NB_NE] = 1'b0;
      mask[NB_E]  = 1'b0;
      mask[NB_SE] = 1'b0;
    end
  end

endmodule

// File: rtl/eda_scan_ctrl.sv
// Raster-scan controller: walks every pixel, strobes the compare unit, and writes its result bit back.
// state | meaning: IDLE wait for start; ISSUE load pixel; WAIT compare settles; WRITE write result; DONE completion pulse
module eda_scan_ctrl
  import eda_pkg::*;
#(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int ADDR_WIDTH = $clog2(M * N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  new_pixel,
  output logic [ADDR_WIDTH-1:0] center_addr,
  output logic [7:0]            neigh_addr_valid,
  input  logic                  compare_out,
  input  logic                  out_ready,
  output logic                  bw_we,
  output logic [ADDR_WIDTH-1:0] bw_addr,
  output logic                  bw_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   max_count
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last_pix;
  logic          start_acc;

  assign last_pix  = (row == RW'(M - 1)) && (col == CW'(N - 1));
  assign start_acc = (state == S_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // abort wins over everything except reset; in IDLE it simply keeps the FSM parked.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_ISSUE;
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT:  state_nxt = S_WRITE;
        S_WRITE: if (out_ready) state_nxt = last_pix ? S_DONE : S_ISSUE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    new_pixel = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    bw_we     = 1'b0;
    new_pixel = (state == S_ISSUE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    bw_we     = (state == S_WRITE) && out_ready && !abort && !reset;
  end

  // Position only advances on an accepted write, so the address is stable for the whole pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      max_count <= '0;
    end else if (start_acc) begin
      row       <= '0;
      col       <= '0;
      max_count <= '0;
    end else if (bw_we) begin
      if (compare_out) max_count <= max_count + 1'b1;
      if (!last_pix) begin
        if (col == CW'(N - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign center_addr = ADDR_WIDTH'(row) * ADDR_WIDTH'(N) + ADDR_WIDTH'(col);
  assign bw_addr     = center_addr;
  assign bw_data     = compare_out;

  eda_nbr_mask #(
    .M (M),
    .N (N),
    .RW(RW),
    .CW(CW)
  ) u_nbr_mask (
    .row (row),
    .col (col),
    .mask(neigh_addr_valid)
  );

endmodule

// File: tb/tb_eda_scan_ctrl.sv
// Directed and randomized bench for eda_scan_ctrl on a 4x4 image.
// Expected cycle behaviour comes from a per-pixel timing schedule and a geometric neighbour model.
module tb_eda_scan_ctrl;

  localparam int M    = 4;
  localparam int N    = 4;
  localparam int AW   = 4;
  localparam int NPIX = M * N;
  localparam int MAXC = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          compare_out;
  logic          out_ready;
  logic          new_pixel;
  logic [AW-1:0] center_addr;
  logic [7:0]    neigh_addr_valid;
  logic          bw_we;
  logic [AW-1:0] bw_addr;
  logic          bw_data;
  logic          busy;
  logic          done;
  logic [AW:0]   max_count;

  int checks = 0;
  int errors = 0;

  int stall[NPIX];
  bit cmpv[NPIX];
  bit rdy_tied;
  int mc_model;

  int e_pix[MAXC];
  bit e_np[MAXC];
  bit e_we[MAXC];
  bit e_done[MAXC];
  bit d_rdy[MAXC];
  bit d_cmp[MAXC];
  int issue_cyc[NPIX];
  int sched_len;

  int done_at;
  int nwr;

  eda_scan_ctrl #(.M(M), .N(N), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .new_pixel       (new_pixel),
    .center_addr     (center_addr),
    .neigh_addr_valid(neigh_addr_valid),
    .compare_out     (compare_out),
    .out_ready       (out_ready),
    .bw_we           (bw_we),
    .bw_addr         (bw_addr),
    .bw_data         (bw_data),
    .busy            (busy),
    .done            (done),
    .max_count       (max_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // A neighbour is valid when its coordinates fall inside the image.
  function automatic logic [7:0] ref_mask(input int pix);
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int r;
    int c;
    logic [7:0] m;
    r = pix / N;
    c = pix % N;
    m = '0;
    for (int b = 0; b < 8; b++)
      if (r + dr[b] >= 0 && r + dr[b] < M && c + dc[b] >= 0 && c + dc[b] < N) m[b] = 1'b1;
    return m;
  endfunction

  // Each pixel costs issue + wait + stalls + one accepted write; done follows the last write.
  task automatic build_sched();
    int c;
    for (int i = 0; i < MAXC; i++) begin
      e_pix[i]  = -1;
      e_np[i]   = 1'b0;
      e_we[i]   = 1'b0;
      e_done[i] = 1'b0;
      d_rdy[i]  = rdy_tied ? 1'b1 : 1'($urandom_range(0, 1));
      d_cmp[i]  = 1'($urandom_range(0, 1));
    end
    c = 1;
    for (int p = 0; p < NPIX; p++) begin
      issue_cyc[p] = c;
      e_pix[c] = p; e_np[c] = 1'b1; c++;
      e_pix[c] = p; c++;
      for (int s = 0; s < stall[p]; s++) begin
        e_pix[c] = p; d_rdy[c] = 1'b0; c++;
      end
      e_pix[c] = p; d_rdy[c] = 1'b1; e_we[c] = 1'b1; d_cmp[c] = cmpv[p]; c++;
    end
    e_done[c] = 1'b1;
    sched_len = c + 1;
  endtask

  // Runs one scan started at relative cycle 0; kill_pix >= 0 kills it in that pixel's WAIT cycle.
  task automatic run_scan(input string nm, input int kill_pix, input bit kill_rst, input int stray_cyc);
    int kill_cyc;
    int ncyc;
    int mc_run;
    bit post;
    build_sched();
    kill_cyc = (kill_pix >= 0) ? issue_cyc[kill_pix] + 1 : -1;
    ncyc     = (kill_cyc >= 0) ? kill_cyc + 4 : sched_len + 3;
    mc_run   = mc_model;
    done_at  = -1;
    nwr      = 0;
    for (int c = 0; c < ncyc; c++) begin
      post        = (kill_cyc >= 0) && (c > kill_cyc);
      start       = (c == 0) || (c == stray_cyc);
      abort       = (c == kill_cyc) && !kill_rst;
      reset       = (c == kill_cyc) && kill_rst;
      out_ready   = d_rdy[c];
      compare_out = d_cmp[c];
      @(negedge clk);
      if (done === 1'b1 && done_at < 0) done_at = c;
      if (bw_we === 1'b1) nwr++;
      if (post) begin
        chk({nm, " busy_after_kill"}, busy, 0);
        chk({nm, " we_after_kill"}, bw_we, 0);
        chk({nm, " np_after_kill"}, new_pixel, 0);
        chk({nm, " done_after_kill"}, done, 0);
        chk({nm, " mc_after_kill"}, max_count, kill_rst ? 0 : mc_run);
      end else begin
        chk({nm, " busy"}, busy, (e_pix[c] >= 0 || e_done[c]) ? 1 : 0);
        chk({nm, " new_pixel"}, new_pixel, e_np[c]);
        chk({nm, " bw_we"}, bw_we, (e_we[c] && c != kill_cyc) ? 1 : 0);
        chk({nm, " done"}, done, e_done[c]);
        chk({nm, " max_count"}, max_count, mc_run);
        if (e_pix[c] >= 0) begin
          chk({nm, " center_addr"}, center_addr, e_pix[c]);
          chk({nm, " mask"}, neigh_addr_valid, ref_mask(e_pix[c]));
        end
        if (e_np[c] && e_pix[c] == 0)  chk({nm, " mask_px0"}, neigh_addr_valid, 8'b1101_0000);
        if (e_np[c] && e_pix[c] == 5)  chk({nm, " mask_px5"}, neigh_addr_valid, 8'hFF);
        if (e_np[c] && e_pix[c] == 15) chk({nm, " mask_px15"}, neigh_addr_valid, 8'b0000_1011);
        if (e_we[c] && c != kill_cyc) begin
          chk({nm, " bw_addr"}, bw_addr, e_pix[c]);
          chk({nm, " bw_data"}, bw_data, d_cmp[c]);
        end
      end
      if (c == 0) mc_run = 0;
      if (e_we[c] && d_cmp[c] && (kill_cyc < 0 || c < kill_cyc)) mc_run++;
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    abort    = 1'b0;
    reset    = 1'b0;
    mc_model = kill_rst ? 0 : mc_run;
  endtask

  task automatic idle_cycles(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({nm, " idle_busy"}, busy, 0);
      chk({nm, " idle_mc"}, max_count, mc_model);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_pattern();
    for (int p = 0; p < NPIX; p++) begin
      stall[p] = 0;
      cmpv[p]  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b1;
    abort       = 1'b1;
    compare_out = 1'b0;
    out_ready   = 1'b1;
    rdy_tied    = 1'b1;
    mc_model    = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst new_pixel", new_pixel, 0);
    chk("rst bw_we", bw_we, 0);
    chk("rst done", done, 0);
    chk("rst max_count", max_count, 0);
    @(posedge clk);
    #1;

    // Free-running raster scan with out_ready tied high.
    clear_pattern();
    rdy_tied = 1'b1;
    run_scan("raster", -1, 1'b0, -1);
    chk("raster done_cycle", done_at, 49);
    chk("raster writes", nwr, 16);

    // Five-cycle write stall on pixel 6.
    clear_pattern();
    stall[6] = 5;
    run_scan("stall6", -1, 1'b0, -1);
    chk("stall6 done_cycle", done_at, 54);
    chk("stall6 writes", nwr, 16);

    // Regional maxima at 3, 9, 12 only.
    clear_pattern();
    for (int p = 0; p < NPIX; p++) cmpv[p] = (p == 3 || p == 9 || p == 12);
    run_scan("max3", -1, 1'b0, -1);
    chk("max3 count", max_count, 3);
    idle_cycles("max3_hold", 5);

    // Abort in WAIT of pixel 7 with a stray start mid-scan, then a fresh scan.
    clear_pattern();
    run_scan("abort7", 7, 1'b0, 10);
    chk("abort7 no_done", done_at, -1);
    chk("abort7 writes", nwr, 7);
    idle_cycles("abort7_idle", 2);
    rdy_tied = 1'b0;
    clear_pattern();
    for (int p = 0; p < NPIX; p++) stall[p] = $urandom_range(0, 3);
    run_scan("rescan", -1, 1'b0, -1);
    chk("rescan writes", nwr, 16);

    // Reset in the middle of a scan.
    clear_pattern();
    for (int p = 0; p < NPIX; p++) cmpv[p] = 1'b1;
    run_scan("midrst", 9, 1'b1, -1);
    chk("midrst writes", nwr, 9);
    idle_cycles("midrst_idle", 2);

    // Randomized scans.
    for (int k = 0; k < 3; k++) begin
      clear_pattern();
      for (int p = 0; p < NPIX; p++) stall[p] = $urandom_range(0, 4);
      run_scan("rand", -1, 1'b0, $urandom_range(2, 30));
      chk("rand writes", nwr, 16);
    end

    // abort alone, and abort together with start, while idle.
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    idle_cycles("idle_abort", 1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    idle_cycles("idle_abort_start", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eda_scan_ctrl.md
EDA_SCAN_CTRL -- requirements
Module: eda_scan_ctrl

Interface
REQ-001 SHALL have parameter M, default 16, image rows.
REQ-002 SHALL have parameter N, default 16, image columns.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(M*N), pixel address width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a full-image scan; honoured only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate the scan in progress.
REQ-008 SHALL have port new_pixel  output  1  one-cycle load strobe to the compare unit.
REQ-009 SHALL have port center_addr  output  ADDR_WIDTH  current pixel address, row*N+col.
REQ-010 SHALL have port neigh_addr_valid  output  8  boundary mask of in-image neighbours.
REQ-011 SHALL have port compare_out  input  1  regional-max result from the compare unit.
REQ-012 SHALL have port out_ready  input  1  result memory can accept a write.
REQ-013 SHALL have port bw_we  output  1  result write enable.
REQ-014 SHALL have port bw_addr  output  ADDR_WIDTH  result write address.
REQ-015 SHALL have port bw_data  output  1  result bit, equal to compare_out.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at scan completion.
REQ-018 SHALL have port max_count  output  ADDR_WIDTH+1  number of pixels written with bw_data=1.

Function
REQ-019 FSM SHALL use states IDLE, ISSUE, WAIT, WRITE and DONE.
REQ-020 Transitions SHALL be:
- IDLE->ISSUE on start, clearing row, col and max_count.
- ISSUE->WAIT unconditionally.
- WAIT->WRITE unconditionally.
- WRITE->ISSUE when out_ready and not the last pixel.
- WRITE->DONE when out_ready and the last pixel.
- WRITE holds while out_ready=0.
- DONE->IDLE unconditionally.
REQ-021 new_pixel SHALL be 1 exactly in ISSUE; center_addr and neigh_addr_valid SHALL be stable from ISSUE through WRITE.
REQ-022 bw_we SHALL equal (state==WRITE && out_ready); in that cycle bw_addr=center_addr and bw_data=compare_out.
REQ-023 max_count SHALL increment on each write with bw_data=1 and hold its value after done until the next accepted start.
REQ-024 Scan order SHALL be raster: col increments first; at col=N-1, col wraps to 0 and row increments; the last pixel is row=M-1, col=N-1.
REQ-025 Neighbour bit order SHALL be 0=NW, 1=N, 2=NE, 3=W, 4=E, 5=SW, 6=S, 7=SE.
REQ-026 Mask bits SHALL be cleared as follows, with the clears combining:
- row=0 clears bits 0, 1, 2.
- row=M-1 clears bits 5, 6, 7.
- col=0 clears bits 0, 3, 5.
- col=N-1 clears bits 2, 4, 7.
REQ-027 Per-pixel cost SHALL be 3 cycles plus the number of out_ready=0 cycles spent in WRITE.
REQ-028 done SHALL assert in the DONE cycle, one cycle after the last write.
REQ-029 start while busy SHALL be ignored.
REQ-030 abort SHALL force IDLE on the next edge from any state, with no write in that cycle and no done pulse; abort has priority over out_ready.
REQ-031 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-032 reset SHALL be sampled only on the rising clk edge and SHALL override start and abort.
REQ-033 Reset SHALL place the FSM in IDLE and set row, col, max_count, new_pixel, bw_we, busy and done to 0.
REQ-034 Reset applied mid-scan SHALL discard the scan, and the first cycle after reset release SHALL show all outputs at their reset values.

Structure
REQ-035 Package eda_pkg SHALL hold the state enum and the eight neighbour-index constants; the compare and writeback blocks SHALL use the same constants.
REQ-036 The boundary-mask logic SHALL be a combinational sub-module eda_nbr_mask (inputs row, col; output 8-bit mask).

Verification
REQ-037 With M=N=4: reset asserted mid-scan -> next cycle busy=0, bw_we=0, max_count=0, FSM in IDLE.
REQ-038 With M=N=4 and out_ready tied 1, start at cycle 0:
- 16 writes occur, to addresses 0..15 in order.
- done pulses at cycle 49.
- Mask at addr 0 = 8'b1101_0000; at addr 5 = 8'hFF; at addr 15 = 8'b0000_1011.
REQ-039 With M=N=4, out_ready=0 for 5 cycles at addr 6 -> bw_we stays 0 during the stall, exactly one write to addr 6, done delayed by 5 cycles.
REQ-040 With M=N=4, compare_out=1 on addrs 3, 9 and 12 -> max_count=3 after done and holds through the following idle cycles.
REQ-041 With M=N=4, abort in WAIT of addr 7 -> no write to addr 7, no done, IDLE next cycle; a start during the scan is ignored; a fresh start rescans from addr 0 with max_count cleared.
